// File: rtl/folded_threshold_eval.sv
// ---------------------------------------------------------------------------
// folded_threshold_eval
//
// Sequential threshold / majority evaluator. An N-bit vector arrives as a
// stream of LANES-bit chunks (chunk k carries x[k*LANES+i] on bit i). The
// popcount is accumulated chunk by chunk. When the vector is complete, the
// decision (count >= THRESH) and the count are presented on a valid/ready
// result port.
//
// Optional build macro: FOLDED_EARLY_EXIT_EN
//   When defined, a vector's result is issued as soon as it can no longer
//   change. That is the case once the count has reached THRESH, or once the
//   bits still to come cannot lift it to THRESH. The remaining chunks of that
//   vector are still consumed, but they do not produce a second result. When
//   the macro is undefined, out_early is tied low.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   chunk present on in_data
//   in_ready   block can accept a chunk (!out_valid || out_ready)
//   in_data    LANES-bit chunk
//   out_valid  result held on out_y / out_count / out_early
//   out_ready  consumer takes the result
//   out_y      1 when count >= THRESH
//   out_count  popcount used for the decision
//   out_early  result decided before the final chunk
//   busy       a vector is partially accepted (chunk index != 0)
// ---------------------------------------------------------------------------
module folded_threshold_eval #(
    parameter int N      = 47,
    parameter int LANES  = 8,
    parameter int THRESH = (N + 1) / 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_y,
    output logic [$clog2(N+1)-1:0]   out_count,
    output logic                     out_early,
    output logic                     busy
);

    localparam int CHUNKS    = (N + LANES - 1) / LANES;
    localparam int CW        = $clog2(N + 1);
    localparam int IW        = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    // Number of live lanes in the final chunk; lanes above this are padding.
    localparam int LAST_BITS = N - (CHUNKS - 1) * LANES;
    localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Population count of one chunk. On the final chunk, the padding lanes are
    // dropped so that garbage above bit N-1 never reaches the count.
    function automatic logic [CW-1:0] masked_popcount(input logic [LANES-1:0] data,
                                                      input logic last);
        logic [CW-1:0] cnt;
        cnt = {CW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            cnt = cnt + CW'(data[i] && (!last || (i < LAST_BITS)));
        end
        return cnt;
    endfunction

`ifdef FOLDED_EARLY_EXIT_EN
    // Bits of the vector still to arrive once chunk idx has been accepted.
    function automatic int bits_after(input logic [IW-1:0] idx);
        int done_bits;
        done_bits = (int'(idx) + 1) * LANES;
        return (done_bits >= N) ? 0 : (N - done_bits);
    endfunction
`endif

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic            out_valid_q, out_valid_d;
    logic            out_y_q, out_y_d;
    logic [CW-1:0]   out_count_q, out_count_d;
    logic            out_early_q, out_early_d;
    logic            busy_q, busy_d;
`ifdef FOLDED_EARLY_EXIT_EN
    logic            decided_q, decided_d;
    logic            decide_hi_s;
    logic            decide_lo_s;
`endif

    logic            in_ready_s;
    logic            accept_s;
    logic            is_last_s;
    logic [CW-1:0]   chunk_pop_s;
    logic [CW-1:0]   acc_sum_s;
    logic            load_s;
    logic            load_early_s;

    // A consumed result frees the register in the same cycle, so a new chunk
    // may be taken while the old result is being handed over.
    assign in_ready_s = !out_valid_q || out_ready;

    // Chunk acceptance, running count and result-load decision.
    always_comb begin
        accept_s     = in_valid && in_ready_s;
        is_last_s    = (idx_q == LAST_IDX);
        chunk_pop_s  = masked_popcount(in_data, is_last_s);
        acc_sum_s    = acc_q + chunk_pop_s;
        load_s       = 1'b0;
        load_early_s = 1'b0;
`ifdef FOLDED_EARLY_EXIT_EN
        decide_hi_s  = (int'(acc_sum_s) >= THRESH);
        decide_lo_s  = ((int'(acc_sum_s) + bits_after(idx_q)) < THRESH);
        decided_d    = decided_q;
        // On the final chunk no bits remain, so one of the two tests always
        // holds. A vector that has not decided yet therefore resolves there.
        if (accept_s && !decided_q && (decide_hi_s || decide_lo_s)) begin
            load_s       = 1'b1;
            load_early_s = !is_last_s;
        end else begin
            load_s       = 1'b0;
            load_early_s = 1'b0;
        end
        if (accept_s) begin
            decided_d = is_last_s ? 1'b0 : (decided_q || load_s);
        end else begin
            decided_d = decided_q;
        end
`else
        load_s       = accept_s && is_last_s;
        load_early_s = 1'b0;
`endif
    end

    // Next-state logic; IDLE always corresponds to chunk index 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !is_last_s) begin
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && is_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Chunk index and accumulator; both clear when the last chunk is taken.
    always_comb begin
        idx_d = idx_q;
        acc_d = acc_q;
        if (accept_s) begin
            if (is_last_s) begin
                idx_d = {IW{1'b0}};
                acc_d = {CW{1'b0}};
            end else begin
                idx_d = idx_q + 1'b1;
                acc_d = acc_sum_s;
            end
        end else begin
            idx_d = idx_q;
            acc_d = acc_q;
        end
        busy_d = (idx_d != {IW{1'b0}});
    end

    // Result register: a new result takes priority over the handshake clear.
    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_count_d = out_count_q;
        out_early_d = out_early_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            out_y_d     = (int'(acc_sum_s) >= THRESH);
            out_count_d = acc_sum_s;
            out_early_d = load_early_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State, datapath and result flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IW{1'b0}};
            acc_q       <= {CW{1'b0}};
            out_valid_q <= 1'b0;
            out_y_q     <= 1'b0;
            out_count_q <= {CW{1'b0}};
            out_early_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef FOLDED_EARLY_EXIT_EN
            decided_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_count_q <= out_count_d;
            out_early_q <= out_early_d;
            busy_q      <= busy_d;
`ifdef FOLDED_EARLY_EXIT_EN
            decided_q   <= decided_d;
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_count = out_count_q;
    assign out_early = out_early_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_folded_threshold_eval.sv
module tb_folded_threshold_eval;

    localparam int N      = 47;
    localparam int LANES  = 8;
    localparam int THRESH = (N + 1) / 2;
    localparam int CHUNKS = (N + LANES - 1) / LANES;
    localparam int CW     = $clog2(N + 1);

    typedef logic [LANES-1:0] chunks_t [CHUNKS];
    typedef struct {
        logic y;
        int   count;
        logic early;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [LANES-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_y;
    logic [CW-1:0]     out_count;
    logic              out_early;
    logic              busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   rand_ready_en = 1'b0;
    res_t exp_q[$];
    int   res_cycles[$];

    folded_threshold_eval #(.N(N), .LANES(LANES), .THRESH(THRESH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_count (out_count),
        .out_early (out_early),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: count the live bits of the vector. In the early-exit build,
    // the result is taken at the first chunk after which the outcome is fixed.
    function automatic res_t model(input chunks_t ch);
        res_t r;
        int   cnt;
        int   rem;
        bit   done;
        cnt  = 0;
        done = 1'b0;
        r.y = 1'b0; r.count = 0; r.early = 1'b0;
        for (int k = 0; k < CHUNKS; k++) begin
            for (int i = 0; i < LANES; i++) begin
                if ((k * LANES + i) < N && ch[k][i]) cnt++;
            end
            rem = N - (k + 1) * LANES;
            if (rem < 0) rem = 0;
`ifdef FOLDED_EARLY_EXIT_EN
            if (!done && (cnt >= THRESH || cnt + rem < THRESH)) begin
                done    = 1'b1;
                r.y     = (cnt >= THRESH);
                r.count = cnt;
                r.early = (k < CHUNKS - 1);
            end
`endif
        end
        if (!done) begin
            r.y = (cnt >= THRESH); r.count = cnt; r.early = 1'b0;
        end
        return r;
    endfunction

    function automatic chunks_t mk(input logic [7:0] c0, c1, c2, c3, c4, c5);
        chunks_t v;
        v[0] = c0; v[1] = c1; v[2] = c2; v[3] = c3; v[4] = c4; v[5] = c5;
        return v;
    endfunction

    // Result monitor: a result is taken at the next rising edge whenever
    // out_valid && out_ready is seen here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            res_t e;
            res_cycles.push_back(cyc);
            check_val("result_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("res_y", 32'(out_y), 32'(e.y));
                check_val("res_count", 32'(out_count), e.count);
                check_val("res_early", 32'(out_early), 32'(e.early));
            end
        end
    end

    // Random back-pressure on the result port.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_data = LANES'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic push_chunk(input logic [LANES-1:0] d, output int waited);
        bit taken;
        taken  = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!taken) begin
            @(negedge clk);
            if (in_ready) taken = 1'b1;
            else waited++;
            @(posedge clk); #1;
            if (!taken && waited > 300) begin
                check_val("accept_timeout", 32'(waited), 32'd0);
                taken = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_vector(input chunks_t ch, input int gap_max, input bit chk_lat,
                               output int first_wait);
        res_t e;
        int   w;
        e = model(ch);
        exp_q.push_back(e);
        first_wait = 0;
        for (int k = 0; k < CHUNKS; k++) begin
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            push_chunk(ch[k], w);
            if (k == 0) first_wait = w;
        end
        if (chk_lat && !e.early) begin
            @(negedge clk);
            check_val("latency_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        chunks_t v;
        int      fw;
        int      w;
        int      nres;
        int      budget;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_y", 32'(out_y), 32'd0);
        check_val("rst_out_count", 32'(out_count), 32'd0);
        check_val("rst_out_early", 32'(out_early), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Directed vectors from the basic rules.
        send_vector(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 0, 1'b1, fw);
        send_vector(mk(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00), 0, 1'b1, fw);
        send_vector(mk(8'hFF, 8'hFF, 8'h7F, 8'h00, 8'h00, 8'h00), 0, 1'b1, fw);
        send_vector(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80), 0, 1'b1, fw);
        send_vector(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF), 0, 1'b1, fw);
        idle(3);

        // Hold: 0x0F in every chunk only resolves on the last chunk (24 ones).
        out_ready = 1'b0;
        send_vector(mk(8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F), 0, 1'b1, fw);
        repeat (5) begin
            @(negedge clk);
            check_val("hold_valid", 32'(out_valid), 32'd1);
            check_val("hold_in_ready", 32'(in_ready), 32'd0);
            check_val("hold_count", 32'(out_count), 32'd24);
            check_val("hold_y", 32'(out_y), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        nres = res_cycles.size();
        send_vector(mk(8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F), 0, 1'b0, fw);
        check_val("same_cycle_accept_wait", 32'(fw), 32'd0);
        send_vector(mk(8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F), 0, 1'b1, fw);
        idle(3);
        check_val("b2b_results", 32'(res_cycles.size() - nres), 32'd3);
        if (res_cycles.size() >= 2)
            check_val("b2b_spacing",
                      32'(res_cycles[res_cycles.size()-1] - res_cycles[res_cycles.size()-2]),
                      32'd6);

        // Reset in mid-vector, then a full vector of ones.
        idle(5);
        for (int k = 0; k < 4; k++) push_chunk(8'hFF, w);
        @(negedge clk);
        check_val("mid_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_vector(mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 0, 1'b1, fw);
        idle(3);

        // Randomised vectors with input gaps and result back-pressure.
        rand_ready_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            int p;
            p = $urandom_range(0, 100);
            for (int k = 0; k < CHUNKS; k++)
                for (int i = 0; i < LANES; i++)
                    v[k][i] = ($urandom_range(0, 99) < p);
            send_vector(v, $urandom_range(0, 2), 1'b0, fw);
        end
        rand_ready_en = 1'b0;
        out_ready = 1'b1;

        budget = 0;
        while (exp_q.size() > 0 && budget < 500) begin
            idle(1);
            budget++;
        end
        idle(3);
        check_val("drain", 32'(exp_q.size()), 32'd0);
        check_val("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/folded_threshold_eval.md
Name: folded_threshold_eval

Overview:
- Sequential, parametrised successor to the flat 47-input majority gate.
- Accepts an N-bit input vector as a stream of LANES-bit chunks and accumulates the popcount chunk by chunk.
- After the last chunk, returns a threshold decision (count >= THRESH) and the full count through a valid/ready result port.
- Used wherever a wide majority/threshold function is too large to build flat; it trades latency for area.

Parameters:
- N, 47, total input bits per vector (>= 2).
- LANES, 8, bits accepted per chunk (1..N).
- THRESH, (N+1)/2, decision threshold; default gives majority. Legal range 1..N.
- Derived, not overridable: CHUNKS = ceil(N/LANES); CW = $clog2(N+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  chunk present on in_data.
- in_ready  out  1  block can accept a chunk.
- in_data  in  LANES  chunk k carries x[k*LANES+i] on bit i.
- out_valid  out  1  result held on out_y/out_count/out_early.
- out_ready  in  1  consumer takes the result.
- out_y  out  1  1 when count >= THRESH.
- out_count  out  CW  popcount used for the decision.
- out_early  out  1  result was decided before the final chunk (see Optional Feature).
- busy  out  1  a vector is partially accepted (chunk index != 0).

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_y=0, out_count=0, out_early=0, busy=0, accumulator=0, chunk index=0. in_ready=1 after reset.
- Accept rule: chunk is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready.
  - A result may be consumed and a new chunk accepted in the same cycle.
- Accumulation:
  - acc_next = acc + popcount(masked in_data).
  - Chunk index increments 0..CHUNKS-1 and wraps to 0 after the last chunk.
  - On the last chunk only bits 0..(N-1-(CHUNKS-1)*LANES) count; higher lanes are masked and ignored whatever their value.
- States:
  - IDLE (index=0, acc=0) -> ACCUM on first accepted chunk.
  - ACCUM -> ACCUM on each accept until the last chunk.
  - The last accept loads the result register and returns to IDLE. The accumulator clears in the same cycle.
  - When CHUNKS=1, every accepted chunk completes a vector directly.
- Latency: result is visible on out_valid the cycle after the last chunk is accepted. Throughput is one chunk per cycle with no bubbles when out_ready=1.
- Result register: holds stable while out_valid && !out_ready. It is cleared (out_valid=0) on handshake unless a new result loads in the same cycle, in which case the new result wins.
- Arithmetic: accumulator is CW bits wide and cannot overflow because the total is always <= N. Comparison is unsigned.
- Reset mid-vector discards the partial count; the next accepted chunk is treated as chunk 0.
- in_data is ignored when in_valid=0. Chunks offered while in_ready=0 are not consumed and must be held by the producer.

Optional Feature:
- Macro: FOLDED_EARLY_EXIT_EN.
- When defined:
  - After each accepted chunk, the result is issued once acc >= THRESH (out_y=1) or acc + remaining_bits < THRESH (out_y=0).
  - out_count is the partial count at decision time, and out_early=1 when decided before the last chunk.
  - Remaining chunks of that vector are still accepted (index advances) but do not alter the result register.
  - A vector produces exactly one result.
- When not defined: out_early is tied 0, and a decision is made only after the last chunk.

Test Plan:
- All 6 chunks = 0x00 (N=47, LANES=8) -> one cycle after chunk 5, out_valid=1, out_y=0, out_count=0.
- Chunks 0..2 = 0xFF, chunk 3..5 = 0x00 (24 ones) -> out_y=1, out_count=24. Repeat with chunk 2 = 0x7F (23 ones) -> out_y=0, out_count=23.
- Chunks 0..4 = 0x00, chunk 5 = 0x80 (padding lane only) -> out_count=0, out_y=0. Chunk 5 = 0xFF -> out_count=7.
- Result held with out_ready=0 -> in_ready=0, out_* stable for 5 cycles. Raise out_ready together with in_valid -> same-cycle consume and accept; back-to-back vectors produce results 6 cycles apart.
- Assert rst_n=0 after chunk 3 of a vector, then stream a full vector of 47 ones -> out_count=47, out_y=1, no residue from the aborted vector.
- With FOLDED_EARLY_EXIT_EN, chunks 0..2 = 0xFF -> out_valid after chunk 2, out_y=1, out_count=24, out_early=1. Chunks 3..5 are accepted with no second result. Without the macro, the same stimulus gives the result after chunk 5 with out_early=0.
